// File: rtl/d_mem_pkg.sv
// Shared types and the alignment rule for the MEM-stage data memory controller.
package d_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10
  } state_t;

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/d_mem_lane_align.sv
// Little-endian lane steering: byte enables and replicated data for stores,
// lane extraction plus sign/zero extension for loads.
module d_mem_lane_align
  import d_mem_pkg::*;
(
  input  size_t       size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] byte_shifted;
  logic [15:0] half_sel;
  logic        sign_fill;

  assign byte_shifted = rword_i >> {lane_i, 3'b000};
  assign half_sel     = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    be_o      = 4'b0000;
    wdata_o   = wdata_i;
    rdata_o   = rword_i;
    sign_fill = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o      = 4'b0001 << lane_i;
        wdata_o   = {4{wdata_i[7:0]}};
        sign_fill = ~unsigned_i & byte_shifted[7];
        rdata_o   = {{24{sign_fill}}, byte_shifted[7:0]};
      end
      SZ_HALF: begin
        be_o      = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
        sign_fill = ~unsigned_i & half_sel[15];
        rdata_o   = {{16{sign_fill}}, half_sel};
      end
      SZ_WORD: begin
        be_o = 4'b1111;
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/d_mem_ctrl.sv
// Byte/half/word data memory with alignment check and a req/ready handshake
// that inserts WAIT_CYCLES wait states before each access.
module d_mem_ctrl
  import d_mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int LOG_DEPTH   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   memRead,
  input  logic                   memWrite,
  input  logic [1:0]             size,
  input  logic                   unsignedLoad,
  input  logic [LOG_DEPTH+1:0]   dataAddress,
  input  logic [WIDTH-1:0]       writeMemData,
  output logic                   ready,
  output logic                   readValid,
  output logic [WIDTH-1:0]       readMemData,
  output logic                   misaligned
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LOG_DEPTH+1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  size_t                  size_q, size_d;
  logic                   uns_q, uns_d;
  logic                   wr_q, wr_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   mis_q, mis_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];

  logic [3:0]             lane_be;
  logic [WIDTH-1:0]       lane_wdata;
  logic [WIDTH-1:0]       lane_rdata;
  logic [WIDTH-1:0]       cur_word;
  logic                   accept;

  assign cur_word = mem_q[addr_q[LOG_DEPTH+1:2]];
  assign accept   = req & (memRead | memWrite);

  d_mem_lane_align u_lane_align (
    .size_i     (size_q),
    .lane_i     (addr_q[1:0]),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rword_i    (cur_word),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    uns_d    = uns_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    mis_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_misaligned(size_t'(size), dataAddress[1:0])) begin
            mis_d = 1'b1;
          end else begin
            addr_d  = dataAddress;
            wdata_d = writeMemData;
            size_d  = size_t'(size);
            uns_d   = unsignedLoad;
            wr_d    = memWrite;  // read+write together resolves to a write
            if (WAIT_CYCLES > 0) begin
              state_d = WAIT;
              cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            end else begin
              state_d = ACCESS;
            end
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ACCESS: begin
        state_d = IDLE;
        if (!wr_q) begin
          rvalid_d = 1'b1;
          rdata_d  = lane_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= SZ_BYTE;
      uns_q    <= 1'b0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      mis_q    <= mis_d;
    end
  end

  // Storage clears on reset, so an in-flight write is simply lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == ACCESS && wr_q) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_be[l]) mem_q[addr_q[LOG_DEPTH+1:2]][8*l +: 8] <= lane_wdata[8*l +: 8];
      end
    end
  end

  assign ready       = (state_q == IDLE);
  assign readValid   = rvalid_q;
  assign readMemData = rdata_q;
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_d_mem_ctrl.sv
// Directed plus randomized checks of two controller instances (2 and 0 wait
// states) against a byte-array reference model.
module tb_d_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req2, req0, rd, wr, uns;
  logic [1:0]  sz;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        ready2, rv2, mis2, ready0, rv0, mis0;
  logic [31:0] rdata2, rdata0;

  logic [7:0]  mem_m [2][1024];
  logic [31:0] last_m [2];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  d_mem_ctrl #(.WIDTH(32), .LOG_DEPTH(8), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .memRead(rd), .memWrite(wr), .size(sz),
    .unsignedLoad(uns), .dataAddress(addr), .writeMemData(wdata),
    .ready(ready2), .readValid(rv2), .readMemData(rdata2), .misaligned(mis2)
  );

  d_mem_ctrl #(.WIDTH(32), .LOG_DEPTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .memRead(rd), .memWrite(wr), .size(sz),
    .unsignedLoad(uns), .dataAddress(addr), .writeMemData(wdata),
    .ready(ready0), .readValid(rv0), .readMemData(rdata0), .misaligned(mis0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) begin
      mem_m[0][i] = 8'h00;
      mem_m[1][i] = 8'h00;
    end
    last_m[0] = 32'h0;
    last_m[1] = 32'h0;
  endtask

  task automatic chk_outs(input int w, input string tag, input logic e_ready,
                          input logic e_rv, input logic e_mis, input logic [31:0] e_data);
    int k;
    k = (w == 0) ? 0 : 1;
    chk({tag, ".ready"}, 32'(k == 0 ? ready0 : ready2), 32'(e_ready));
    chk({tag, ".rvalid"}, 32'(k == 0 ? rv0 : rv2), 32'(e_rv));
    chk({tag, ".misal"}, 32'(k == 0 ? mis0 : mis2), 32'(e_mis));
    chk({tag, ".rdata"}, k == 0 ? rdata0 : rdata2, e_data);
  endtask

  // Called just after a falling edge; returns just after a falling edge, so
  // back-to-back calls issue requests at the minimum period.
  task automatic xfer(input int w, input logic r, input logic wrr, input logic [1:0] s,
                      input logic u, input logic [9:0] a, input logic [31:0] d,
                      input bit noise, output logic [31:0] got);
    int k;
    logic bad;
    logic [31:0] exp;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    int si;
    k   = (w == 0) ? 0 : 1;
    bad = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
    chk("pre.ready", 32'(k == 0 ? ready0 : ready2), 32'h1);
    rd = r; wr = wrr; sz = s; uns = u; addr = a; wdata = d;
    if (k == 0) req0 = 1'b1; else req2 = 1'b1;
    @(posedge clk); @(negedge clk);
    req0 = 1'b0; req2 = 1'b0;
    if (!(r || wrr) || bad) begin
      chk_outs(w, bad && (r || wrr) ? "misal" : "noop", 1'b1, 1'b0, bad && (r || wrr), last_m[k]);
      got = k == 0 ? rdata0 : rdata2;
      $display("[TB] w=%0d %s sz=%0d addr=%h -> rejected/no-op", w, wrr ? "ST" : "LD", s, a);
      return;
    end
    if (wrr) begin
      case (s)
        2'd0: mem_m[k][a] = d[7:0];
        2'd1: begin mem_m[k][a] = d[7:0]; mem_m[k][a+10'd1] = d[15:8]; end
        default: for (int b = 0; b < 4; b++) mem_m[k][a + 10'(b)] = d[8*b +: 8];
      endcase
    end else begin
      case (s)
        2'd0: begin sb = mem_m[k][a]; si = sb; exp = u ? {24'h0, mem_m[k][a]} : 32'(si); end
        2'd1: begin sh = {mem_m[k][a+10'd1], mem_m[k][a]}; si = sh;
                    exp = u ? {16'h0, mem_m[k][a+10'd1], mem_m[k][a]} : 32'(si); end
        default: exp = {mem_m[k][a+10'd3], mem_m[k][a+10'd2], mem_m[k][a+10'd1], mem_m[k][a]};
      endcase
      last_m[k] = exp;
    end
    for (int i = 0; i <= w; i++) begin
      chk_outs(w, "busy", 1'b0, 1'b0, 1'b0, k == 0 ? rdata0 : rdata2);
      if (noise) begin
        if (k == 0) req0 = 1'b1; else req2 = 1'b1;
        rd = 1'($urandom); wr = 1'($urandom); sz = 2'($urandom);
        addr = 10'($urandom_range(0, 63)); wdata = $urandom;
      end
      @(posedge clk); @(negedge clk);
      req0 = 1'b0; req2 = 1'b0;
    end
    chk_outs(w, "done", 1'b1, !wrr, 1'b0, last_m[k]);
    got = k == 0 ? rdata0 : rdata2;
    $display("[TB] w=%0d %s sz=%0d u=%0d addr=%h data=%h -> rdata=%h", w, wrr ? "ST" : "LD", s, u, a, d, got);
  endtask

  initial begin
    logic [31:0] g;
    rst = 1'b1; req2 = 1'b0; req0 = 1'b0; rd = 1'b0; wr = 1'b0;
    sz = 2'd0; uns = 1'b0; addr = '0; wdata = '0;
    #2 rst = 1'b0;
    #1;
    clear_model();
    chk_outs(2, "reset2", 1'b1, 1'b0, 1'b0, 32'h0);
    chk_outs(0, "reset0", 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed: two wait states
    xfer(2, 0, 1, 2'd2, 0, 10'h010, 32'hDEADBEEF, 0, g);
    xfer(2, 1, 0, 2'd2, 0, 10'h010, 32'h0, 0, g);  chk("plan.lw10", g, 32'hDEADBEEF);
    xfer(2, 0, 1, 2'd0, 0, 10'h013, 32'h000000A5, 0, g);
    xfer(2, 1, 0, 2'd2, 0, 10'h010, 32'h0, 0, g);  chk("plan.lw10b", g, 32'hA5ADBEEF);
    xfer(2, 1, 0, 2'd0, 0, 10'h013, 32'h0, 0, g);  chk("plan.lb13", g, 32'hFFFFFFA5);
    xfer(2, 1, 0, 2'd0, 1, 10'h013, 32'h0, 0, g);  chk("plan.lbu13", g, 32'h000000A5);
    xfer(2, 1, 0, 2'd1, 0, 10'h012, 32'h0, 0, g);  chk("plan.lh12", g, 32'hFFFFA5AD);
    xfer(2, 1, 0, 2'd1, 1, 10'h012, 32'h0, 0, g);  chk("plan.lhu12", g, 32'h0000A5AD);
    xfer(2, 1, 0, 2'd0, 0, 10'h010, 32'h0, 0, g);  chk("plan.lb10", g, 32'hFFFFFFEF);
    xfer(2, 1, 0, 2'd2, 0, 10'h011, 32'h0, 0, g);
    xfer(2, 0, 1, 2'd1, 0, 10'h013, 32'h1234, 0, g);
    xfer(2, 1, 0, 2'd3, 0, 10'h010, 32'h0, 0, g);
    xfer(2, 1, 0, 2'd2, 0, 10'h010, 32'h0, 1, g);  chk("plan.lw10c", g, 32'hA5ADBEEF);
    xfer(2, 1, 1, 2'd2, 0, 10'h014, 32'h55AA33CC, 1, g);
    xfer(2, 1, 0, 2'd2, 0, 10'h014, 32'h0, 0, g);  chk("plan.rdwr", g, 32'h55AA33CC);

    // Reset during WAIT aborts the write and clears memory
    rd = 1'b0; wr = 1'b1; sz = 2'd2; addr = 10'h020; wdata = 32'h12345678; req2 = 1'b1;
    @(posedge clk); @(negedge clk);
    req2 = 1'b0;
    chk("midrst.busy", 32'(ready2), 32'h0);
    #2 rst = 1'b0;
    #1;
    clear_model();
    chk_outs(2, "midrst", 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(2, 1, 0, 2'd2, 0, 10'h020, 32'h0, 0, g);  chk("plan.lw20", g, 32'h0);
    xfer(2, 1, 0, 2'd2, 0, 10'h010, 32'h0, 0, g);  chk("plan.lw10rst", g, 32'h0);

    // Directed: zero wait states, back-to-back
    xfer(0, 0, 1, 2'd2, 0, 10'h004, 32'hCAFEF00D, 0, g);
    xfer(0, 1, 0, 2'd2, 0, 10'h004, 32'h0, 0, g);  chk("plan.w0", g, 32'hCAFEF00D);
    xfer(0, 1, 0, 2'd1, 1, 10'h006, 32'h0, 1, g);  chk("plan.w0lhu", g, 32'h0000CAFE);

    // Randomized traffic on both instances
    for (int n = 0; n < 300; n++) begin
      int w;
      logic r, wrr;
      w   = (n % 2 == 0) ? 2 : 0;
      r   = 1'($urandom);
      wrr = ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 15) != 0 && !r && !wrr) r = 1'b1;
      xfer(w, r, wrr, ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
           1'($urandom), 10'($urandom_range(0, 63)), $urandom, bit'($urandom), g);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
